// File: rtl/seq_datapath_pkg.sv
// Shared encodings for the self-sequencing datapath: opcodes, ALU and shift
// operations, FSM states and status-bit positions.
package seq_datapath_pkg;

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_B = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

    localparam int STAT_Z = 2;
    localparam int STAT_N = 1;
    localparam int STAT_V = 0;

endpackage

// File: rtl/seq_datapath_regfile.sv
// Register file: one synchronous write port, combinational operand and debug
// read ports, every entry cleared by the asynchronous active-low reset.
module regfile_p
    import seq_datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0]  raddr,
    output logic [WIDTH-1:0]         rdata,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int RW = $clog2(NREG);

    logic [WIDTH-1:0] regs [NREG];

    // Registers are discrete flops: the reset must clear every entry at once.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [WIDTH-1:0] q_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q_reg <= '0;
                end else if (we && (waddr == RW'(gi))) begin
                    q_reg <= wdata;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    assign rdata    = regs[raddr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing datapath: accepts one command over valid/ready, walks it
// through operand read, shift/ALU execute and writeback, then pulses done.
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int IMM_W = 8,
    parameter int SHW   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [1:0]               cmd_alu,
    input  logic [1:0]               cmd_shop,
    input  logic [SHW-1:0]           cmd_shamt,
    input  logic [$clog2(NREG)-1:0]  cmd_rd,
    input  logic [$clog2(NREG)-1:0]  cmd_rn,
    input  logic [$clog2(NREG)-1:0]  cmd_rm,
    input  logic [IMM_W-1:0]         cmd_imm,
    output logic                     done,
    output logic [WIDTH-1:0]         C,
    output logic [2:0]               stat_out,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int RW = $clog2(NREG);

    logic [2:0]       state_reg;
    logic [1:0]       op_reg;
    logic [1:0]       alu_reg;
    logic [1:0]       shop_reg;
    logic [SHW-1:0]   shamt_reg;
    logic [RW-1:0]    rd_reg;
    logic [RW-1:0]    rn_reg;
    logic [RW-1:0]    rm_reg;
    logic [IMM_W-1:0] imm_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] c_reg;
    logic [2:0]       stat_reg;

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] sh_val;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       alu_flags;
    logic             alu_ovf;
    logic             rf_we;
    logic [WIDTH-1:0] rf_wdata;
    logic [RW-1:0]    rf_raddr;
    logic [WIDTH-1:0] rf_rdata;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign done      = (state_reg == ST_WB);
    assign C         = c_reg;
    assign stat_out  = stat_reg;
    assign imm_ext   = WIDTH'($signed(imm_reg));

    // One shared read port: rn while fetching A, rm otherwise.
    assign rf_raddr = (state_reg == ST_RD_A) ? rn_reg : rm_reg;
    assign rf_we    = (state_reg == ST_WB) && (op_reg != OP_CMP);
    assign rf_wdata = (op_reg == OP_MOVI) ? imm_ext : c_reg;

    regfile_p #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (rd_reg),
        .wdata    (rf_wdata),
        .raddr    (rf_raddr),
        .rdata    (rf_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Shift amounts at or beyond WIDTH fall out of the native operators:
    // zero for logical shifts, sign fill for the arithmetic one.
    always_comb begin
        sh_val = b_reg;
        case (shop_reg)
            SH_NONE: sh_val = b_reg;
            SH_LSL:  sh_val = b_reg << shamt_reg;
            SH_LSR:  sh_val = b_reg >> shamt_reg;
            SH_ASR:  sh_val = $unsigned($signed(b_reg) >>> shamt_reg);
            default: sh_val = b_reg;
        endcase
    end

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_reg)
            ALU_ADD: begin
                alu_res = a_reg + sh_val;
                alu_ovf = (a_reg[WIDTH-1] == sh_val[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = a_reg - sh_val;
                alu_ovf = (a_reg[WIDTH-1] != sh_val[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_reg[WIDTH-1]);
            end
            ALU_AND:  alu_res = a_reg & sh_val;
            ALU_NOTB: alu_res = ~sh_val;
            default:  alu_res = '0;
        endcase
        alu_flags         = '0;
        alu_flags[STAT_Z] = (alu_res == '0);
        alu_flags[STAT_N] = alu_res[WIDTH-1];
        alu_flags[STAT_V] = alu_ovf;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            alu_reg   <= '0;
            shop_reg  <= '0;
            shamt_reg <= '0;
            rd_reg    <= '0;
            rn_reg    <= '0;
            rm_reg    <= '0;
            imm_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            stat_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_reg    <= cmd_op;
                        alu_reg   <= cmd_alu;
                        shop_reg  <= cmd_shop;
                        shamt_reg <= cmd_shamt;
                        rd_reg    <= cmd_rd;
                        rn_reg    <= cmd_rn;
                        rm_reg    <= cmd_rm;
                        imm_reg   <= cmd_imm;
                        // MOV never reads A, so the ALU sees a zero operand.
                        if (cmd_op == OP_MOV) begin
                            a_reg <= '0;
                        end
                        case (cmd_op)
                            OP_MOVI: state_reg <= ST_WB;
                            OP_MOV:  state_reg <= ST_RD_B;
                            default: state_reg <= ST_RD_A;
                        endcase
                    end
                end
                ST_RD_A: begin
                    a_reg     <= rf_rdata;
                    state_reg <= ST_RD_B;
                end
                ST_RD_B: begin
                    b_reg     <= rf_rdata;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_reg == OP_MOV) begin
                        c_reg <= sh_val;
                    end else begin
                        if (op_reg == OP_ALU) begin
                            c_reg <= alu_res;
                        end
                        stat_reg <= alu_flags;
                    end
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    if (op_reg == OP_MOVI) begin
                        c_reg <= imm_ext;
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_datapath.sv
// Randomised scoreboard bench for seq_datapath: a driver issues commands and
// queues the reference model's expectations, a monitor checks each done pulse.
module tb_seq_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [1:0]  cmd_alu = '0;
    logic [1:0]  cmd_shop = '0;
    logic [3:0]  cmd_shamt = '0;
    logic [2:0]  cmd_rd = '0;
    logic [2:0]  cmd_rn = '0;
    logic [2:0]  cmd_rm = '0;
    logic [7:0]  cmd_imm = '0;
    logic        done;
    logic [15:0] C;
    logic [2:0]  stat_out;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    seq_datapath #(
        .WIDTH (16),
        .NREG  (8),
        .IMM_W (8),
        .SHW   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_alu   (cmd_alu),
        .cmd_shop  (cmd_shop),
        .cmd_shamt (cmd_shamt),
        .cmd_rd    (cmd_rd),
        .cmd_rn    (cmd_rn),
        .cmd_rm    (cmd_rm),
        .cmd_imm   (cmd_imm),
        .done      (done),
        .C         (C),
        .stat_out  (stat_out),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                lat;
        int                acc;
        logic [15:0]       c;
        logic [2:0]        stat;
        logic [7:0][15:0]  regs;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_regs [8];
    logic [15:0] m_c;
    logic [2:0]  m_stat;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] m_shift(input logic [15:0] b, input logic [1:0] shop, input int s);
        int sb;
        case (shop)
            2'd1:    return 16'(32'(b) << s);
            2'd2:    return b >> s;
            2'd3: begin
                sb = $signed(b);
                return 16'(sb >>> s);
            end
            default: return b;
        endcase
    endfunction

    // Reference semantics straight from the command definitions, using
    // signed integer arithmetic for the overflow decision.
    task automatic model_exec(input logic [1:0] op, input logic [1:0] alu, input logic [1:0] shop,
                              input logic [3:0] shamt, input logic [2:0] rd, input logic [2:0] rn,
                              input logic [2:0] rm, input logic [7:0] imm, output int lat);
        logic [15:0] a, b, res;
        int sa, sbv, sum;
        logic v;
        case (op)
            2'd0: begin
                res = {{8{imm[7]}}, imm};
                m_regs[rd] = res;
                m_c = res;
                lat = 1;
            end
            2'd1: begin
                m_c = m_shift(m_regs[rm], shop, int'(shamt));
                m_regs[rd] = m_c;
                lat = 3;
            end
            default: begin
                a = m_regs[rn];
                b = m_shift(m_regs[rm], shop, int'(shamt));
                sa = $signed(a);
                sbv = $signed(b);
                v = 1'b0;
                case (alu)
                    2'd0: begin sum = sa + sbv; res = 16'(sum); v = (sum > 32767) || (sum < -32768); end
                    2'd1: begin sum = sa - sbv; res = 16'(sum); v = (sum > 32767) || (sum < -32768); end
                    2'd2: res = a & b;
                    default: res = ~b;
                endcase
                m_stat = {res == 16'd0, res[15], v};
                if (op == 2'd2) begin
                    m_c = res;
                    m_regs[rd] = res;
                end
                lat = 4;
            end
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_c = '0;
        m_stat = '0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] alu, input logic [1:0] shop,
                         input logic [3:0] shamt, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [7:0] imm, input bit hold, input bit abort);
        int n;
        int lat;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_op = op; cmd_alu = alu; cmd_shop = shop; cmd_shamt = shamt;
        cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (abort) begin
            cmd_valid = 1'b0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            model_reset();
            #1;
            check("abort_ready", 32'(cmd_ready), 32'd1);
            check("abort_done", 32'(done), 32'd0);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check("abort_no_done", 32'(done), 32'd0);
            end
            check("abort_ready_after", 32'(cmd_ready), 32'd1);
            check("abort_C", 32'(C), 32'd0);
            check_all_regs("abort");
            return;
        end
        model_exec(op, alu, shop, shamt, rd, rn, rm, imm, lat);
        e.lat = lat;
        e.acc = cyc;
        e.c = m_c;
        e.stat = m_stat;
        for (int i = 0; i < 8; i++) e.regs[i] = m_regs[i];
        sb_q.push_back(e);
        if (hold) begin
            // Keep presenting junk commands while busy; none may be taken.
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                if (done) break;
                cmd_op = 2'($urandom); cmd_rd = 3'($urandom); cmd_imm = 8'($urandom);
                n++;
            end
            cmd_valid = 1'b0;
        end else begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    // Monitor: each done pops one expectation; results are checked one cycle
    // later, after the writeback edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    @(negedge clk);
                    check("done_width", 32'(done), 32'd0);
                    check("ready_after", 32'(cmd_ready), 32'd1);
                    check("C", 32'(C), 32'(e.c));
                    check("stat", 32'(stat_out), 32'(e.stat));
                    for (int i = 0; i < 8; i++) begin
                        dbg_addr = 3'(i);
                        #1;
                        check($sformatf("reg%0d", i), 32'(dbg_data), 32'(e.regs[i]));
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_C", 32'(C), 32'd0);
        check("rst_stat", 32'(stat_out), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check_all_regs("rst");

        // Directed cases
        issue(2'd0, 2'd0, 2'd0, 4'd0, 3'd3, 3'd0, 3'd0, 8'hF6, 1'b0, 1'b0);
        issue(2'd0, 2'd0, 2'd0, 4'd0, 3'd1, 3'd0, 3'd0, 8'hFF, 1'b0, 1'b0);
        issue(2'd1, 2'd0, 2'd2, 4'd1, 3'd1, 3'd0, 3'd1, 8'h00, 1'b0, 1'b0);
        issue(2'd0, 2'd0, 2'd0, 4'd0, 3'd2, 3'd0, 3'd0, 8'h01, 1'b0, 1'b0);
        issue(2'd2, 2'd0, 2'd0, 4'd0, 3'd0, 3'd1, 3'd2, 8'h00, 1'b0, 1'b0);
        issue(2'd0, 2'd0, 2'd0, 4'd0, 3'd7, 3'd0, 3'd0, 8'h01, 1'b0, 1'b0);
        issue(2'd1, 2'd0, 2'd1, 4'd15, 3'd7, 3'd0, 3'd7, 8'h00, 1'b0, 1'b0);
        issue(2'd0, 2'd0, 2'd0, 4'd0, 3'd6, 3'd0, 3'd0, 8'h01, 1'b0, 1'b0);
        issue(2'd2, 2'd0, 2'd0, 4'd0, 3'd2, 3'd7, 3'd6, 8'h00, 1'b0, 1'b0);
        issue(2'd1, 2'd0, 2'd3, 4'd3, 3'd4, 3'd0, 3'd2, 8'h00, 1'b0, 1'b0);
        issue(2'd1, 2'd0, 2'd2, 4'd15, 3'd4, 3'd0, 3'd2, 8'h00, 1'b0, 1'b0);
        issue(2'd1, 2'd0, 2'd1, 4'd15, 3'd4, 3'd0, 3'd2, 8'h00, 1'b0, 1'b0);
        issue(2'd3, 2'd1, 2'd0, 4'd0, 3'd5, 3'd5, 3'd5, 8'h00, 1'b1, 1'b0);
        issue(2'd2, 2'd1, 2'd0, 4'd0, 3'd2, 3'd2, 3'd2, 8'h00, 1'b0, 1'b0);

        // Randomised commands
        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom),
                  3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0), 1'b0);
        end

        // Reset in the middle of an ALU command, then resume
        issue(2'd0, 2'd0, 2'd0, 4'd0, 3'd6, 3'd0, 3'd0, 8'h5A, 1'b0, 1'b0);
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        issue(2'd2, 2'd0, 2'd0, 4'd0, 3'd6, 3'd6, 3'd6, 8'h00, 1'b0, 1'b1);
        issue(2'd0, 2'd0, 2'd0, 4'd0, 3'd1, 3'd0, 3'd0, 8'h12, 1'b0, 1'b0);

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
